// File: rtl/display_seq_pkg.sv
// Shared types and defaults for the display sequencer.
package display_seq_pkg;

   localparam int CODE_W           = 4;
   localparam int HOLD_CYCLES_DEF  = 8;
   localparam int BLANK_CYCLES_DEF = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHOW  = 2'd1,
      BLANK = 2'd2
   } state_t;

endpackage

// File: rtl/display_seq_fifo.sv
// DEPTH-entry code queue. The head entry is visible combinationally on dout so
// the sequencer can latch it on the same edge it pops. flush wins over push/pop.
module display_seq_fifo
   import display_seq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              push,
   input  logic              pop,
   input  logic [CODE_W-1:0] din,
   output logic [CODE_W-1:0] dout,
   output logic [CW-1:0]     count,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(DEPTH);

   logic [CODE_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              push_ok;
   logic              pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full & ~flush;
   assign pop_ok  = pop & ~empty & ~flush;
   assign dout    = mem[rd_ptr];

   // Storage array: written only on an accepted push, contents need no reset.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/display_sequencer.sv
// Display sequencer: queues 4-bit codes and shows each one for HOLD_CYCLES
// cycles with disp_ready high. Define DISPLAY_SEQ_BLANK_EN to insert a
// BLANK_CYCLES gap (disp_code 0000) after every shown code.
module display_sequencer
   import display_seq_pkg::*;
#(
   parameter int HOLD_CYCLES  = HOLD_CYCLES_DEF,
   parameter int DEPTH        = 4,
   parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [CODE_W-1:0]        in_code,
   output logic                     in_ready,
   input  logic                     flush,
   output logic [CODE_W-1:0]        disp_code,
   output logic                     disp_ready,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int          CW        = $clog2(DEPTH) + 1;
   localparam logic [7:0]  HOLD_LOAD = 8'(HOLD_CYCLES - 1);

   // Reject out-of-range configurations at elaboration.
   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255 || BLANK_CYCLES < 1 || BLANK_CYCLES > 255 ||
       DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
      $error("display_sequencer: parameter out of legal range");
   end

   state_t            state;
   logic [7:0]        hold_cnt;
   logic              hold_done;
   logic [CODE_W-1:0] head;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;

`ifdef DISPLAY_SEQ_BLANK_EN
   localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES - 1);
   logic [7:0] blank_cnt;
   logic       blank_done;
   assign blank_done = (blank_cnt == 8'd0);
`endif

   assign in_ready  = ~full;
   assign push      = in_valid & in_ready;
   assign busy      = (state != IDLE);
   assign hold_done = (hold_cnt == 8'd0);

   display_seq_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .din   (in_code),
      .dout  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // Pop whenever the FSM is about to start showing a new code.
   always_comb begin
      pop = 1'b0;
      if (!flush && !empty) begin
         case (state)
            IDLE: pop = 1'b1;
            SHOW: begin
`ifndef DISPLAY_SEQ_BLANK_EN
               pop = hold_done;
`endif
            end
`ifdef DISPLAY_SEQ_BLANK_EN
            BLANK: pop = blank_done;
`endif
            default: pop = 1'b0;
         endcase
      end
   end

   // Sequencer FSM with registered display outputs; flush aborts but keeps disp_code.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         hold_cnt   <= 8'd0;
         disp_code  <= '0;
         disp_ready <= 1'b0;
`ifdef DISPLAY_SEQ_BLANK_EN
         blank_cnt  <= 8'd0;
`endif
      end else if (flush) begin
         state      <= IDLE;
         disp_ready <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  disp_code  <= head;
                  hold_cnt   <= HOLD_LOAD;
                  disp_ready <= 1'b1;
                  state      <= SHOW;
               end
            end
            SHOW: begin
               if (hold_done) begin
`ifdef DISPLAY_SEQ_BLANK_EN
                  state      <= BLANK;
                  disp_ready <= 1'b0;
                  disp_code  <= '0;
                  blank_cnt  <= BLANK_LOAD;
`else
                  if (pop) begin
                     // Back-to-back: next code replaces the current one with no gap.
                     disp_code <= head;
                     hold_cnt  <= HOLD_LOAD;
                  end else begin
                     state      <= IDLE;
                     disp_ready <= 1'b0;
                  end
`endif
               end else begin
                  hold_cnt <= hold_cnt - 8'd1;
               end
            end
`ifdef DISPLAY_SEQ_BLANK_EN
            BLANK: begin
               if (blank_done) begin
                  if (pop) begin
                     disp_code  <= head;
                     hold_cnt   <= HOLD_LOAD;
                     disp_ready <= 1'b1;
                     state      <= SHOW;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  blank_cnt <= blank_cnt - 8'd1;
               end
            end
`endif
            default: begin
               state      <= IDLE;
               disp_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
